// File: rtl/mem_read_arbiter.sv
// rtl/mem_read_arbiter.sv - round-robin arbiter sharing one AXI4-Lite read channel among N masters
module mem_read_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N-1:0]           m_ARvalid,
  output logic [N-1:0]           m_ARready,
  input  logic [32*N-1:0]        m_ARdata,
  input  logic [3*N-1:0]         m_arprot,
  output logic [N-1:0]           m_Rvalid,
  input  logic [N-1:0]           m_RReady,
  output logic [31:0]            m_Rdata,
  output logic                   ARvalid,
  input  logic                   ARready,
  output logic [31:0]            ARdata,
  output logic [2:0]             arprot,
  input  logic                   Rvalid,
  output logic                   RReady,
  input  logic [31:0]            Rdata,
  output logic [$clog2(N)-1:0]   owner,
  output logic                   busy,
  output logic                   timeout
);

  localparam int OW = $clog2(N);
  localparam logic [OW-1:0] LAST_IDX = OW'(N - 1);
  localparam bit WD_EN = (TIMEOUT > 0);
  // Counter value seen in the cycle the watchdog must fire (TIMEOUT cycles after grant).
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

  state_t          state;
  state_t          next_state;
  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   rr;
  logic [31:0]     addr_q;
  logic [2:0]      prot_q;
  logic [31:0]     wd_cnt;

  logic            req_any;
  logic [OW-1:0]   sel;
  logic [31:0]     sel_addr;
  logic [2:0]      sel_prot;
  int              idx;

  logic            data_done;
  logic            err_done;
  logic            wd_fire;

  // Pick the first requesting master at or after the round-robin pointer, wrapping at N.
  always_comb begin
    req_any  = 1'b0;
    sel      = '0;
    sel_addr = '0;
    sel_prot = '0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr) + k) % N;
      if (!req_any && m_ARvalid[idx]) begin
        req_any  = 1'b1;
        sel      = OW'(idx);
        sel_addr = m_ARdata[32*idx +: 32];
        sel_prot = m_arprot[3*idx +: 3];
      end
    end
  end

  // Completion and watchdog conditions; a completing read beats a simultaneous expiry.
  always_comb begin
    data_done = (state == DATA) && Rvalid && m_RReady[owner_q];
    err_done  = (state == ERR) && m_RReady[owner_q];
    wd_fire   = WD_EN && ((state == ADDR) || (state == DATA)) &&
                (wd_cnt == WD_LAST) && !data_done;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_any) next_state = ADDR;
      ADDR: begin
        if (wd_fire)      next_state = ERR;
        else if (ARready) next_state = DATA;
      end
      DATA: begin
        if (data_done)    next_state = IDLE;
        else if (wd_fire) next_state = ERR;
      end
      ERR:  if (err_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Grant latch, round-robin pointer and watchdog counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q <= '0;
      rr      <= '0;
      addr_q  <= '0;
      prot_q  <= '0;
      wd_cnt  <= '0;
    end else begin
      if ((state == IDLE) && req_any) begin
        owner_q <= sel;
        addr_q  <= sel_addr;
        prot_q  <= sel_prot;
        wd_cnt  <= '0;
      end else if ((state == ADDR) || (state == DATA)) begin
        wd_cnt  <= wd_cnt + 32'd1;
      end
      if (data_done || err_done) begin
        rr <= (owner_q == LAST_IDX) ? '0 : owner_q + OW'(1);
      end
    end
  end

  // Per-master handshakes and read data steering; non-owners always see zero.
  always_comb begin
    m_ARready = '0;
    m_Rvalid  = '0;
    m_Rdata   = '0;
    RReady    = 1'b0;
    case (state)
      IDLE: if (req_any) m_ARready[sel] = 1'b1;
      DATA: begin
        RReady            = m_RReady[owner_q];
        m_Rvalid[owner_q] = Rvalid;
        m_Rdata           = Rdata;
      end
      ERR:  m_Rvalid[owner_q] = 1'b1;
      default: ;
    endcase
  end

  assign ARvalid = (state == ADDR);
  assign ARdata  = addr_q;
  assign arprot  = prot_q;
  assign owner   = owner_q;
  assign busy    = (state != IDLE);
  assign timeout = wd_fire;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb/tb_mem_read_arbiter.sv - directed and randomized checks for mem_read_arbiter
module tb_mem_read_arbiter;

  localparam int N  = 3;
  localparam int TO = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    m_ARvalid, m_ARready, m_Rvalid, m_RReady;
  logic [32*N-1:0] m_ARdata;
  logic [3*N-1:0]  m_arprot;
  logic [31:0]     m_Rdata, ARdata, Rdata;
  logic [2:0]      arprot;
  logic            ARvalid, ARready, Rvalid, RReady, busy, timeout;
  logic [1:0]      owner;

  int   checks = 0;
  int   errors = 0;
  logic s_pend;

  always #5 clock = ~clock;

  mem_read_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .m_ARvalid(m_ARvalid), .m_ARready(m_ARready), .m_ARdata(m_ARdata), .m_arprot(m_arprot),
    .m_Rvalid(m_Rvalid), .m_RReady(m_RReady), .m_Rdata(m_Rdata),
    .ARvalid(ARvalid), .ARready(ARready), .ARdata(ARdata), .arprot(arprot),
    .Rvalid(Rvalid), .RReady(RReady), .Rdata(Rdata),
    .owner(owner), .busy(busy), .timeout(timeout)
  );

  function automatic logic [N-1:0] onehot(input int i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  function automatic logic [31:0] addr_of(input int i);
    addr_of = 32'h1000 * (i + 1);
  endfunction

  task automatic do_reset();
    reset = 1'b1; m_ARvalid = '0; m_RReady = '0; m_ARdata = '0; m_arprot = '0;
    ARready = 1'b0; Rvalid = 1'b0; Rdata = '0; s_pend = 1'b0;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if ({ARvalid, RReady, busy, timeout, m_ARready, m_Rvalid} !== 10'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 0", {ARvalid, RReady, busy, timeout, m_ARready, m_Rvalid}); end
    checks++; if ({owner, ARdata, arprot} !== 37'b0) begin errors++; $display("FAIL reset_regs: got %h expected 0", {owner, ARdata, arprot}); end
    @(negedge clock);
  endtask

  task automatic test_single();
    do_reset();
    m_ARvalid = 3'b001; m_ARdata[31:0] = 32'h100; m_arprot[2:0] = 3'b101; #1;
    checks++; if (m_ARready !== 3'b001) begin errors++; $display("FAIL single_grant: got %b expected 001", m_ARready); end
    @(negedge clock);
    m_ARvalid = 3'b000; #1;
    checks++; if ({ARvalid, ARdata, arprot} !== {1'b1, 32'h100, 3'b101}) begin errors++; $display("FAIL single_addr: got %h expected %h", {ARvalid, ARdata, arprot}, {1'b1, 32'h100, 3'b101}); end
    @(negedge clock);
    ARready = 1'b1; #1;
    checks++; if (ARvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid_hold: got %b expected 1", ARvalid); end
    @(negedge clock);
    ARready = 1'b0; m_RReady = 3'b001; #1;
    checks++; if ({m_Rvalid, busy} !== 4'b0001) begin errors++; $display("FAIL single_wait: got %b expected 0001", {m_Rvalid, busy}); end
    @(negedge clock);
    Rvalid = 1'b1; Rdata = 32'hCAFE_0001; #1;
    checks++; if ({m_Rvalid, m_Rdata, owner, RReady} !== {3'b001, 32'hCAFE_0001, 2'd0, 1'b1}) begin errors++; $display("FAIL single_data: got %h expected %h", {m_Rvalid, m_Rdata, owner, RReady}, {3'b001, 32'hCAFE_0001, 2'd0, 1'b1}); end
    @(negedge clock);
    Rvalid = 1'b0; m_RReady = '0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", busy); end
    @(negedge clock);
  endtask

  // Immediate slave and always-ready masters; checks grant order against a cyclic sequence.
  task automatic run_fair(input logic [N-1:0] reqs, input int period, input string tag);
    int ng, last_o;
    do_reset();
    for (int i = 0; i < N; i++) m_ARdata[32*i +: 32] = addr_of(i);
    m_ARvalid = reqs; ng = 0; last_o = 0;
    for (int c = 0; c < 60 && ng < 5; c++) begin
      ARready = ARvalid; Rvalid = s_pend; Rdata = 32'h1111_0000 + c; m_RReady = '1;
      #1;
      checks++; if ($countones(m_ARready) > 1) begin errors++; $display("FAIL %s_onehot: got %b expected at most one bit", tag, m_ARready); end
      if (m_ARready != '0) begin
        last_o = ng % period;
        checks++; if (m_ARready !== onehot(last_o)) begin errors++; $display("FAIL %s_grant%0d: got %b expected %b", tag, ng, m_ARready, onehot(last_o)); end
        ng++;
      end
      if (ARvalid && ARready) begin
        checks++; if (ARdata !== addr_of(last_o)) begin errors++; $display("FAIL %s_ardata: got %h expected %h", tag, ARdata, addr_of(last_o)); end
        s_pend = 1'b1;
      end
      if (Rvalid && RReady) s_pend = 1'b0;
      @(negedge clock);
    end
    checks++; if (ng != 5) begin errors++; $display("FAIL %s_count: got %0d expected 5", tag, ng); end
  endtask

  task automatic test_alternate();
    run_fair(3'b011, 2, "alt");
  endtask

  task automatic test_wrap();
    run_fair(3'b111, 3, "wrap");
  endtask

  task automatic test_stall();
    do_reset();
    m_ARdata[31:0] = 32'hA0; m_ARdata[63:32] = 32'hB0;
    m_ARvalid = 3'b001; #1;
    @(negedge clock);
    m_ARvalid = 3'b010; ARready = 1'b1; #1;
    checks++; if (m_ARready !== 3'b000) begin errors++; $display("FAIL stall_no_grant_addr: got %b expected 000", m_ARready); end
    @(negedge clock);
    ARready = 1'b0; Rvalid = 1'b1; Rdata = 32'h5555_AAAA; m_RReady = 3'b000;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if ({RReady, m_Rvalid, m_ARready, m_Rdata} !== {1'b0, 3'b001, 3'b000, 32'h5555_AAAA}) begin errors++; $display("FAIL stall_cycle%0d: got %h expected %h", c, {RReady, m_Rvalid, m_ARready, m_Rdata}, {1'b0, 3'b001, 3'b000, 32'h5555_AAAA}); end
      @(negedge clock);
    end
    m_RReady = 3'b001; #1;
    checks++; if (RReady !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", RReady); end
    @(negedge clock);
    Rvalid = 1'b0; m_RReady = '0; #1;
    checks++; if (m_ARready !== 3'b010) begin errors++; $display("FAIL stall_next_grant: got %b expected 010", m_ARready); end
    @(negedge clock);
  endtask

  task automatic test_timeout();
    do_reset();
    m_ARvalid = 3'b100; #1;
    checks++; if (m_ARready !== 3'b100) begin errors++; $display("FAIL to_grant: got %b expected 100", m_ARready); end
    @(negedge clock);
    m_ARvalid = '0;
    for (int k = 1; k < TO; k++) begin
      ARready = (k == 1); #1;
      checks++; if ({timeout, busy} !== 2'b01) begin errors++; $display("FAIL to_early%0d: got %b expected 01", k, {timeout, busy}); end
      @(negedge clock);
    end
    ARready = 1'b0; #1;
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", timeout); end
    @(negedge clock);
    Rvalid = 1'b1; Rdata = 32'hDEAD_BEEF; #1;
    checks++; if ({m_Rvalid, m_Rdata, RReady, ARvalid, timeout} !== {3'b100, 32'h0, 3'b000}) begin errors++; $display("FAIL to_err: got %h expected %h", {m_Rvalid, m_Rdata, RReady, ARvalid, timeout}, {3'b100, 32'h0, 3'b000}); end
    @(negedge clock);
    m_RReady = 3'b100; #1;
    checks++; if ({m_Rvalid, RReady} !== 4'b1000) begin errors++; $display("FAIL to_err_ack: got %b expected 1000", {m_Rvalid, RReady}); end
    @(negedge clock);
    m_RReady = '0; Rvalid = 1'b0; #1;
    checks++; if ({busy, m_Rvalid} !== 4'b0) begin errors++; $display("FAIL to_idle: got %b expected 0000", {busy, m_Rvalid}); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ARvalid = 3'b010; #1;
    @(negedge clock);
    m_ARvalid = '0; ARready = 1'b1; #1;
    @(negedge clock);
    ARready = 1'b0; #1;
    checks++; if ({busy, owner} !== 3'b101) begin errors++; $display("FAIL rmid_in_data: got %b expected 101", {busy, owner}); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; #1;
    checks++; if ({ARvalid, RReady, busy, timeout, m_ARready, m_Rvalid, owner} !== 12'b0) begin errors++; $display("FAIL rmid_cleared: got %b expected 0", {ARvalid, RReady, busy, timeout, m_ARready, m_Rvalid, owner}); end
    @(negedge clock);
    m_ARvalid = 3'b111; #1;
    checks++; if (m_ARready !== 3'b001) begin errors++; $display("FAIL rmid_restart: got %b expected 001", m_ARready); end
    @(negedge clock);
  endtask

  // Random masters and slave latencies against a transaction-level round-robin model.
  task automatic test_random();
    logic [31:0] tab [N][8];
    int nreq [N], head [N], gap [N];
    int rr_m, cur, win, total, ntx, ar_wait, ar_dly, s_wait, r_dly, mr_wait, mr_dly;
    bit in_txn, ar_done, finished;
    logic [31:0] cur_addr, s_data;
    logic [2:0]  cur_prot;
    logic [N-1:0] exp_ar;
    do_reset();
    total = 0; ntx = 0; rr_m = 0; cur = 0; in_txn = 0; ar_done = 0; finished = 0;
    ar_wait = 0; ar_dly = 0; s_wait = 0; r_dly = 0; mr_wait = 0; mr_dly = 0; s_data = '0;
    cur_addr = '0; cur_prot = '0;
    for (int i = 0; i < N; i++) begin
      nreq[i] = $urandom_range(3, 8); head[i] = 0; gap[i] = $urandom_range(0, 3);
      total += nreq[i];
      for (int j = 0; j < 8; j++) tab[i][j] = $urandom & 32'hFFFF_FFFC;
      m_arprot[3*i +: 3] = 3'(i + 3);
    end
    for (int c = 0; c < 2000 && !finished; c++) begin
      for (int i = 0; i < N; i++) begin
        m_ARvalid[i] = (head[i] < nreq[i]) && (gap[i] == 0);
        m_ARdata[32*i +: 32] = m_ARvalid[i] ? tab[i][head[i]] : $urandom;
      end
      ARready = ARvalid && (ar_wait >= ar_dly);
      Rvalid  = s_pend && (s_wait >= r_dly);
      Rdata   = Rvalid ? s_data : $urandom;
      m_RReady = 3'($urandom_range(0, 7));
      if (Rvalid) m_RReady[cur] = (mr_wait >= mr_dly);
      #1;
      exp_ar = '0; win = -1;
      if (!in_txn) begin
        for (int k = 0; k < N; k++)
          if (win < 0 && m_ARvalid[(rr_m + k) % N]) win = (rr_m + k) % N;
        if (win >= 0) exp_ar = onehot(win);
      end
      checks++; if (m_ARready !== exp_ar) begin errors++; $display("FAIL rand_arready c%0d: got %b expected %b", c, m_ARready, exp_ar); end
      checks++; if ({ARvalid, busy, timeout} !== {in_txn && !ar_done, in_txn, 1'b0}) begin errors++; $display("FAIL rand_status c%0d: got %b expected %b", c, {ARvalid, busy, timeout}, {in_txn && !ar_done, in_txn, 1'b0}); end
      if (in_txn) begin
        checks++; if (owner !== 2'(cur)) begin errors++; $display("FAIL rand_owner c%0d: got %0d expected %0d", c, owner, cur); end
      end
      if (ARvalid && in_txn && !ar_done) begin
        checks++; if ({ARdata, arprot} !== {cur_addr, cur_prot}) begin errors++; $display("FAIL rand_ardata c%0d: got %h expected %h", c, {ARdata, arprot}, {cur_addr, cur_prot}); end
      end
      checks++; if (m_Rvalid !== (Rvalid ? onehot(cur) : 3'b000)) begin errors++; $display("FAIL rand_rvalid c%0d: got %b expected %b", c, m_Rvalid, Rvalid ? onehot(cur) : 3'b000); end
      if (Rvalid) begin
        checks++; if ({m_Rdata, RReady} !== {s_data, m_RReady[cur]}) begin errors++; $display("FAIL rand_rdata c%0d: got %h expected %h", c, {m_Rdata, RReady}, {s_data, m_RReady[cur]}); end
      end
      for (int i = 0; i < N; i++) if (!m_ARvalid[i] && gap[i] > 0) gap[i]--;
      if (ARvalid && ARready) begin
        ar_done = 1; s_pend = 1'b1; s_wait = 0; r_dly = $urandom_range(0, 1);
        s_data = $urandom; mr_wait = 0; mr_dly = $urandom_range(0, 1);
      end else if (ARvalid) ar_wait++;
      if (Rvalid && m_RReady[cur]) begin
        s_pend = 1'b0; in_txn = 0; rr_m = (cur + 1) % N; ntx++;
      end else if (s_pend) begin
        s_wait++;
        if (Rvalid) mr_wait++;
      end
      if (win >= 0) begin
        in_txn = 1; ar_done = 0; cur = win; cur_addr = tab[win][head[win]];
        cur_prot = 3'(win + 3); head[win]++; gap[win] = $urandom_range(0, 3);
        ar_wait = 0; ar_dly = $urandom_range(0, 2);
      end
      finished = (ntx == total);
      @(negedge clock);
    end
    checks++; if (ntx != total) begin errors++; $display("FAIL rand_completed: got %0d expected %0d", ntx, total); end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_wrap();
    test_random();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
